// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
//
// Collects a gapped serial bit stream into WIDTH-bit words, first bit = MSB.
// A word starts on a strobed bit with i_frame=1. After WIDTH bits the word is
// offered on o_data/o_valid with a ready/valid handshake. A word that
// completes while the previous one is still unconsumed is dropped, and the
// drop is flagged in the sticky o_overrun. A new frame marker arriving
// mid-word restarts reception and pulses o_frame_err for one cycle.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_sdata      serial data bit (sampled when i_sbit_en=1)
//   i_sbit_en    bit strobe
//   i_frame      word-start marker, qualified by i_sbit_en
//   i_ready      downstream accepts o_data while o_valid=1
//   i_clr_ovr    clears o_overrun
//   o_data       last completed word
//   o_valid      o_data holds an unconsumed word
//   o_busy       word reception in progress
//   o_overrun    sticky: a completed word was dropped
//   o_frame_err  one-cycle pulse: word restarted before completion
// ---------------------------------------------------------------------------
module deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sdata,
    input  logic             i_sbit_en,
    input  logic             i_frame,
    input  logic             i_ready,
    input  logic             i_clr_ovr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SR_W  = WIDTH - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SR_W-1:0]    sr_q,    sr_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic               valid_q, valid_d;
    logic               ovr_q,   ovr_d;
    logic               ferr_q,  ferr_d;

    // Shift register with the incoming bit appended; on the final bit this
    // is the complete word, otherwise its low WIDTH-1 bits are the new sr.
    logic [WIDTH-1:0]   shifted;
    logic [SR_W-1:0]    first_bit;
    logic               done;

    assign shifted   = {sr_q, i_sdata};
    assign first_bit = SR_W'(i_sdata);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ferr_d  = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                // Strobed bits outside a frame are discarded.
                if (i_sbit_en && i_frame) begin
                    sr_d    = first_bit;
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (i_sbit_en) begin
                    if (i_frame) begin
                        // Frame marker wins even on what would be the last bit.
                        sr_d   = first_bit;
                        cnt_d  = CNT_W'(1);
                        ferr_d = 1'b1;
                    end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sr_d  = shifted[SR_W-1:0];
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (i_clr_ovr) begin
            ovr_d = 1'b0;
        end

        if (done) begin
            // Accept the new word if the output slot is free or is being
            // emptied on this same edge; otherwise drop it.
            if (!valid_q || i_ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_busy      = (state_q == SHIFT);
    assign o_overrun   = ovr_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
//
// Directed bench for deserializer (WIDTH=8). Inputs are driven 1 time unit
// after the rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_deserializer;

    localparam int WIDTH = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_sdata;
    logic             i_sbit_en;
    logic             i_frame;
    logic             i_ready;
    logic             i_clr_ovr;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_busy;
    logic             o_overrun;
    logic             o_frame_err;

    int n_checks;
    int n_fail;

    deserializer #(.WIDTH(WIDTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sdata     (i_sdata),
        .i_sbit_en   (i_sbit_en),
        .i_frame     (i_frame),
        .i_ready     (i_ready),
        .i_clr_ovr   (i_clr_ovr),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    // One strobed bit, then all strobe-qualified inputs return to 0.
    task automatic bit1(input logic fr, input logic d);
        i_sbit_en = 1'b1;
        i_frame   = fr;
        i_sdata   = d;
        cycle();
        i_sbit_en = 1'b0;
        i_frame   = 1'b0;
        i_sdata   = 1'b0;
    endtask

    // Full framed word, MSB first. gap<0 selects a varying 0..3 idle gap.
    // rdy_last/clr_last are asserted only on the final bit's edge.
    task automatic send_word(input logic [7:0] w, input int gap,
                             input logic rdy_last, input logic clr_last);
        for (int i = 7; i >= 0; i--) begin
            i_sbit_en = 1'b1;
            i_sdata   = w[i];
            i_frame   = (i == 7);
            if (i == 0) begin
                i_ready   = rdy_last;
                i_clr_ovr = clr_last;
            end
            cycle();
            i_sbit_en = 1'b0;
            i_frame   = 1'b0;
            i_sdata   = 1'b0;
            i_ready   = 1'b0;
            i_clr_ovr = 1'b0;
            if (i > 0) repeat ((gap < 0) ? (i % 4) : gap) cycle();
        end
    endtask

    task automatic consume();
        i_ready = 1'b1;
        cycle();
        i_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        i_rst     = 1'b1;
        i_sdata   = 1'b1;
        i_sbit_en = 1'b1;
        i_frame   = 1'b1;
        i_ready   = 1'b1;
        i_clr_ovr = 1'b0;
        // Reset must dominate active strobe/frame inputs.
        cycle();
        cycle();
        i_sbit_en = 1'b0;
        i_frame   = 1'b0;
        i_sdata   = 1'b0;
        i_ready   = 1'b0;
        check("rst_data",  o_data,      32'h0);
        check("rst_valid", o_valid,     32'h0);
        check("rst_busy",  o_busy,      32'h0);
        check("rst_ovr",   o_overrun,   32'h0);
        check("rst_ferr",  o_frame_err, 32'h0);
        i_rst = 1'b0;
        cycle();

        // Back-to-back 0xA5, ready low.
        send_word(8'hA5, 0, 1'b0, 1'b0);
        check("a5_data",  o_data,  32'hA5);
        check("a5_valid", o_valid, 32'h1);
        check("a5_busy",  o_busy,  32'h0);
        cycle();
        check("a5_hold",  o_data,  32'hA5);
        consume();
        check("a5_taken", o_valid, 32'h0);
        // Ready while nothing is pending has no effect.
        consume();
        check("rdy_idle", o_valid, 32'h0);

        // Stray bits outside a frame, then gapped 0xA5.
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b0);
        check("stray_busy",  o_busy,  32'h0);
        check("stray_valid", o_valid, 32'h0);
        send_word(8'hA5, -1, 1'b0, 1'b0);
        check("gap_data",  o_data,  32'hA5);
        check("gap_valid", o_valid, 32'h1);
        consume();

        // Overrun: 0x3C then 0xC3 with ready low.
        send_word(8'h3C, 0, 1'b0, 1'b0);
        check("3c_data", o_data, 32'h3C);
        send_word(8'hC3, 1, 1'b0, 1'b0);
        check("ovr_data",  o_data,    32'h3C);
        check("ovr_flag",  o_overrun, 32'h1);
        check("ovr_valid", o_valid,   32'h1);
        i_clr_ovr = 1'b1;
        cycle();
        i_clr_ovr = 1'b0;
        check("clr_flag", o_overrun, 32'h0);
        check("clr_data", o_data,    32'h3C);

        // 0x3C still pending; ready on the completing edge of 0xC3.
        send_word(8'hC3, 0, 1'b1, 1'b0);
        check("swap_data",  o_data,    32'hC3);
        check("swap_valid", o_valid,   32'h1);
        check("swap_ovr",   o_overrun, 32'h0);
        consume();

        // Resync: frame + 4 bits, then framed 0x5A.
        bit1(1'b1, 1'b1);
        check("frm_ferr0", o_frame_err, 32'h0);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        bit1(1'b1, 1'b0);
        check("rsync_ferr", o_frame_err, 32'h1);
        check("rsync_busy", o_busy,      32'h1);
        bit1(1'b0, 1'b1);
        check("rsync_pulse", o_frame_err, 32'h0);
        bit1(1'b0, 1'b0);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b0);
        bit1(1'b0, 1'b1);
        check("rsync_pend", o_valid, 32'h0);
        bit1(1'b0, 1'b0);
        check("rsync_data",  o_data,  32'h5A);
        check("rsync_valid", o_valid, 32'h1);
        consume();

        // Reset after 5 bits, stray bits ignored, then 0xFF.
        bit1(1'b1, 1'b0);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        check("mrst_valid", o_valid, 32'h0);
        check("mrst_busy",  o_busy,  32'h0);
        check("mrst_data",  o_data,  32'h0);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        bit1(1'b0, 1'b1);
        check("mrst_stray", o_valid, 32'h0);
        send_word(8'hFF, 0, 1'b0, 1'b0);
        check("ff_data",  o_data,    32'hFF);
        check("ff_valid", o_valid,   32'h1);
        check("ff_ovr",   o_overrun, 32'h0);

        // Clear coinciding with a new overrun keeps the flag set.
        send_word(8'h12, 0, 1'b0, 1'b1);
        check("clr_vs_ovr", o_overrun, 32'h1);
        check("clr_vs_dat", o_data,    32'hFF);
        i_clr_ovr = 1'b1;
        cycle();
        i_clr_ovr = 1'b0;
        check("clr_final", o_overrun, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_sdata  input  1  serial data bit, sampled only when i_sbit_en=1.
REQ-005 i_sbit_en  input  1  bit strobe; one serial bit per cycle with i_sbit_en=1, arbitrary gaps allowed.
REQ-006 i_frame  input  1  word-start marker, qualified by i_sbit_en, asserted with first (MSB) bit of a word.
REQ-007 i_ready  input  1  downstream accepts o_data when o_valid=1.
REQ-008 i_clr_ovr  input  1  clears o_overrun.
REQ-009 o_data  output  WIDTH  last completed word, MSB = first bit received.
REQ-010 o_valid  output  1  o_data holds an unconsumed word.
REQ-011 o_busy  output  1  word reception in progress (state SHIFT).
REQ-012 o_overrun  output  1  sticky: a completed word was dropped.
REQ-013 o_frame_err  output  1  one-cycle pulse: word restarted before completion.

Function
REQ-014 Two states: IDLE, SHIFT; bit counter cnt of width ceil(log2(WIDTH+1)); shift register sr of WIDTH-1 bits.
REQ-015 IDLE: i_sbit_en=1 and i_frame=1 -> sr <= {.., i_sdata}, cnt <= 1, go SHIFT; i_sbit_en=1 without i_frame -> bit ignored, stay IDLE.
REQ-016 SHIFT: i_sbit_en=1, i_frame=0 -> sr shifts left, i_sdata enters LSB, cnt increments.
REQ-017 SHIFT: i_sbit_en=0 -> sr, cnt unchanged (gaps of any length tolerated).
REQ-018 Completion: the edge sampling bit number WIDTH (cnt = WIDTH-1, i_sbit_en=1, i_frame=0) forms word {sr[WIDTH-2:0], i_sdata}, returns to IDLE, cnt <= 0.
REQ-019 Latency: completed word visible on o_data with o_valid=1 in the cycle after the final bit's sampling edge.
REQ-020 Resync: i_sbit_en=1 and i_frame=1 while in SHIFT -> partial word discarded, o_frame_err=1 for exactly one cycle, reception restarts with this bit as bit 1 (cnt <= 1), stay SHIFT.
REQ-021 Handshake: transfer occurs on an edge with o_valid=1 and i_ready=1; o_valid deasserts after it unless a new word completes on the same edge.
REQ-022 o_data stable while o_valid=1 and no transfer occurs.
REQ-023 Completion with o_valid=0 -> o_data loads word, o_valid <= 1.
REQ-024 Completion with o_valid=1 and i_ready=1 on same edge -> old word consumed, new word loaded, o_valid stays 1, no overrun.
REQ-025 Completion with o_valid=1 and i_ready=0 -> new word dropped, o_data unchanged, o_overrun <= 1.
REQ-026 o_overrun held until i_clr_ovr=1 or reset; if i_clr_ovr and a new overrun coincide, o_overrun stays 1.
REQ-027 i_ready ignored when o_valid=0.
REQ-028 o_busy = 1 exactly when state is SHIFT.

Reset
REQ-029 i_rst=1 at a rising edge -> state IDLE, cnt=0, sr=0, o_data=0, o_valid=0, o_busy=0, o_overrun=0, o_frame_err=0; reset dominates all other inputs.
REQ-030 Reset mid-word discards partial word; first word after reset requires a new i_frame.

Verification
REQ-031 WIDTH=8, frame + bits 1,0,1,0,0,1,0,1 on consecutive strobes, i_ready=0 -> o_data=0xA5, o_valid=1 cycle after 8th bit, o_busy low.
REQ-032 Same word with 0-3 idle cycles between strobes, bits outside a frame before it -> o_data=0xA5, stray bits ignored.
REQ-033 Words 0x3C then 0xC3, i_ready=0 throughout -> o_data=0x3C, o_overrun=1; pulse i_clr_ovr -> o_overrun=0, o_data still 0x3C.
REQ-034 0x3C pending, i_ready=1 on the edge 0xC3 completes -> o_data=0xC3, o_valid=1, o_overrun=0.
REQ-035 Frame, 4 bits, new frame + 0x5A -> o_frame_err pulse one cycle at restart, o_data=0x5A.
REQ-036 i_rst=1 after 5 bits, then full 0xFF frame -> o_valid=0 after reset, then o_data=0xFF, o_overrun=0.
